// File: rtl/bit_scan_pkg.sv
// Shared types and helpers for the bit-scan serializer and its priority encoder.
package bit_scan_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Position width for a WIDTH-bit vector; at least one bit for WIDTH = 2.
  function automatic int pos_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/bit_scan_serializer_prio_enc.sv
// Combinational lowest/highest-set-bit encoder; pos is 0 when no bit is set.
module prio_enc #(
  parameter int WIDTH = 8,
  parameter int POS_W = 3
) (
  input  logic [WIDTH-1:0] vec,
  input  logic             msb_first,
  output logic [POS_W-1:0] pos,
  output logic             any
);

  // Later iterations override earlier ones, so loop direction picks the winner.
  always_comb begin
    pos = '0;
    any = |vec;
    if (msb_first) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) pos = POS_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) pos = POS_W'(i);
      end
    end
  end

endmodule

// File: rtl/bit_scan_serializer.sv
// Serialises the set-bit positions of an accepted vector, one index per output beat.
module bit_scan_serializer
  import bit_scan_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int POS_W = pos_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_,
  input  logic             msb_first,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [POS_W-1:0] out_pos,
  output logic [POS_W:0]   out_idx,
  output logic             out_last,
  output logic             out_none
);

  if (WIDTH < 2) begin : g_width_check
    $error("bit_scan_serializer: WIDTH must be at least 2");
  end

  state_t           state, state_next;
  logic [WIDTH-1:0] mask, mask_next;
  logic             dir, dir_next;
  logic [POS_W:0]   idx, idx_next;

  logic [POS_W-1:0] enc_pos;
  logic             enc_any;
  logic             scanning;
  logic             multi;
  logic             fire;
  logic             accept;

  prio_enc #(
    .WIDTH(WIDTH),
    .POS_W(POS_W)
  ) u_enc (
    .vec      (mask),
    .msb_first(dir),
    .pos      (enc_pos),
    .any      (enc_any)
  );

  // Clearing the lowest set bit leaves something only if two or more were set.
  always_comb begin
    scanning  = (state == SCAN);
    multi     = |(mask & (mask - WIDTH'(1)));
    out_valid = scanning;
    out_pos   = scanning ? enc_pos : '0;
    out_idx   = scanning ? idx : '0;
    out_last  = scanning && !multi;
    out_none  = scanning && !enc_any;
    fire      = out_valid && out_ready;
    in_ready  = (state == IDLE) || (fire && out_last);
    accept    = in_valid && in_ready;
  end

  // A new vector loaded on the last-beat cycle overrides the return to IDLE.
  always_comb begin
    state_next = state;
    mask_next  = mask;
    dir_next   = dir;
    idx_next   = idx;
    if (fire) begin
      mask_next = mask & ~(WIDTH'(1) << enc_pos);
      idx_next  = idx + (POS_W + 1)'(1);
      if (out_last) state_next = IDLE;
    end
    if (accept) begin
      mask_next  = in_;
      dir_next   = msb_first;
      idx_next   = '0;
      state_next = SCAN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mask  <= '0;
      dir   <= 1'b0;
      idx   <= '0;
    end else begin
      state <= state_next;
      mask  <= mask_next;
      dir   <= dir_next;
      idx   <= idx_next;
    end
  end

endmodule

// File: tb/tb_bit_scan_serializer.sv
// Self-checking bench: scoreboard of expected beats plus hand-written corner sequences.
module tb_bit_scan_serializer;

  typedef struct {
    int pos;
    int idx;
    bit last;
    bit none;
  } beat_t;

  typedef struct {
    logic [7:0] vec;
    logic       msb;
    int         beats;
    int         first;
  } vec_t;

  logic       clk;
  logic       rst8, rst5;
  logic       in_valid8, in_ready8, msb8, out_valid8, out_ready8;
  logic [7:0] in8;
  logic [2:0] out_pos8;
  logic [3:0] out_idx8;
  logic       out_last8, out_none8;
  logic       in_valid5, in_ready5, msb5, out_valid5, out_ready5;
  logic [4:0] in5;
  logic [2:0] out_pos5;
  logic [3:0] out_idx5;
  logic       out_last5, out_none5;

  beat_t sb[$];
  vec_t  table_v[9];
  int    checks;
  int    failures;
  int    beats_done;
  int    first_pos;
  int    accept_cnt;

  bit_scan_serializer #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(rst8), .in_valid(in_valid8), .in_ready(in_ready8), .in_(in8),
    .msb_first(msb8), .out_valid(out_valid8), .out_ready(out_ready8), .out_pos(out_pos8),
    .out_idx(out_idx8), .out_last(out_last8), .out_none(out_none8)
  );

  bit_scan_serializer #(.WIDTH(5)) dut5 (
    .clk(clk), .reset(rst5), .in_valid(in_valid5), .in_ready(in_ready5), .in_(in5),
    .msb_first(msb5), .out_valid(out_valid5), .out_ready(out_ready5), .out_pos(out_pos5),
    .out_idx(out_idx5), .out_last(out_last5), .out_none(out_none5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference beat list: set-bit positions in scan order, or one zero-vector beat.
  task automatic push_expected(input logic [7:0] v, input logic msb);
    int    list[$];
    beat_t b;
    for (int i = 0; i < 8; i++) if (v[i]) list.push_back(i);
    if (msb) list.reverse();
    if (list.size() == 0) begin
      b.pos = 0; b.idx = 0; b.last = 1'b1; b.none = 1'b1;
      sb.push_back(b);
    end else begin
      for (int k = 0; k < list.size(); k++) begin
        b.pos = list[k]; b.idx = k; b.last = (k == list.size() - 1); b.none = 1'b0;
        sb.push_back(b);
      end
    end
  endtask

  task automatic monitor8();
    bit exp_valid;
    bit exp_ready;
    exp_valid = (sb.size() != 0);
    exp_ready = !exp_valid || (out_ready8 && sb[0].last);
    checkOutput("out_valid8", out_valid8, exp_valid);
    checkOutput("in_ready8", in_ready8, exp_ready);
    if (exp_valid && out_valid8) begin
      checkOutput("out_pos8", out_pos8, sb[0].pos);
      checkOutput("out_idx8", out_idx8, sb[0].idx);
      checkOutput("out_last8", out_last8, sb[0].last);
      checkOutput("out_none8", out_none8, sb[0].none);
    end
    if (rst8) begin
      sb.delete();
    end else begin
      if (exp_valid && out_ready8) begin
        if (sb[0].idx == 0) first_pos = out_pos8;
        beats_done++;
        void'(sb.pop_front());
      end
      if (in_valid8 && exp_ready) begin
        push_expected(in8, msb8);
        accept_cnt++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor8();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic msb, input bit hold);
    int start;
    bit ok;
    start = accept_cnt;
    ok = 1'b0;
    in_valid8 = 1'b1;
    in8 = v;
    msb8 = msb;
    for (int n = 0; n < 40; n++) begin
      step();
      if (accept_cnt != start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("accept_timeout", 0, 1);
    if (!hold) in_valid8 = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output int cycles);
    cycles = 0;
    while (sb.size() != 0 && cycles < bound) begin
      step();
      cycles++;
    end
    if (sb.size() != 0) checkOutput("idle_timeout", 0, 1);
  endtask

  initial begin
    int cyc;
    int start;
    checks = 0; failures = 0; beats_done = 0; first_pos = -1; accept_cnt = 0;
    rst8 = 1'b1; rst5 = 1'b1;
    in_valid8 = 1'b0; in8 = '0; msb8 = 1'b0; out_ready8 = 1'b1;
    in_valid5 = 1'b0; in5 = '0; msb5 = 1'b0; out_ready5 = 1'b1;

    table_v[0] = '{8'b1010_0100, 1'b0, 3, 2};
    table_v[1] = '{8'b1010_0100, 1'b1, 3, 7};
    table_v[2] = '{8'h00, 1'b0, 1, 0};
    table_v[3] = '{8'hFF, 1'b0, 8, 0};
    table_v[4] = '{8'h81, 1'b1, 2, 7};
    table_v[5] = '{8'h10, 1'b0, 1, 4};
    table_v[6] = '{8'h01, 1'b1, 1, 0};
    table_v[7] = '{8'h80, 1'b0, 1, 7};
    table_v[8] = '{8'h3C, 1'b1, 4, 5};

    step();
    step();
    rst8 = 1'b0; rst5 = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready8, 1);
    checkOutput("rst_out_valid", out_valid8, 0);
    checkOutput("rst_out_pos", out_pos8, 0);
    checkOutput("rst_out_idx", out_idx8, 0);
    checkOutput("rst_out_last", out_last8, 0);
    checkOutput("rst_out_none", out_none8, 0);

    for (int t = 0; t < 9; t++) begin
      beats_done = 0;
      first_pos = -1;
      applyStimulus(table_v[t].vec, table_v[t].msb, 1'b0);
      wait_idle(40, cyc);
      checkOutput($sformatf("tbl%0d_beats", t), beats_done, table_v[t].beats);
      checkOutput($sformatf("tbl%0d_first", t), first_pos, table_v[t].first);
    end

    // Zero vector: its single beat cycle must also accept the next vector.
    beats_done = 0;
    applyStimulus(8'h00, 1'b0, 1'b1);
    in8 = 8'h06;
    #1;
    checkOutput("zero_none", out_none8, 1);
    checkOutput("zero_last", out_last8, 1);
    checkOutput("zero_in_ready", in_ready8, 1);
    start = accept_cnt;
    step();
    in_valid8 = 1'b0;
    checkOutput("zero_next_accepted", accept_cnt - start, 1);
    wait_idle(40, cyc);
    checkOutput("zero_pair_beats", beats_done, 3);

    // All ones with out_ready toggling: transfers on every other cycle.
    beats_done = 0;
    applyStimulus(8'hFF, 1'b0, 1'b0);
    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      out_ready8 = (cyc % 2 == 0);
      step();
      cyc++;
    end
    out_ready8 = 1'b1;
    checkOutput("ff_cycles", cyc, 15);
    checkOutput("ff_beats", beats_done, 8);

    // Back-to-back: 0x81 then 0x10 with in_valid held high.
    beats_done = 0;
    applyStimulus(8'h81, 1'b0, 1'b1);
    in8 = 8'h10;
    start = accept_cnt;
    cyc = 0;
    while (sb.size() != 0 && cyc < 40) begin
      step();
      cyc++;
      if (accept_cnt != start) in_valid8 = 1'b0;
    end
    in_valid8 = 1'b0;
    checkOutput("b2b_cycles", cyc, 3);
    checkOutput("b2b_beats", beats_done, 3);
    checkOutput("b2b_accepts", accept_cnt - start, 1);

    // WIDTH=5: reset after the first beat drops the pending bit 4.
    in5 = 5'b10010; msb5 = 1'b0; in_valid5 = 1'b1; out_ready5 = 1'b1;
    step();
    in_valid5 = 1'b0;
    #1;
    checkOutput("w5_valid", out_valid5, 1);
    checkOutput("w5_pos0", out_pos5, 1);
    checkOutput("w5_idx0", out_idx5, 0);
    checkOutput("w5_last0", out_last5, 0);
    step();
    checkOutput("w5_pos1", out_pos5, 4);
    checkOutput("w5_last1", out_last5, 1);
    rst5 = 1'b1; out_ready5 = 1'b0; in_valid5 = 1'b1; in5 = 5'b00111;
    step();
    rst5 = 1'b0; in_valid5 = 1'b0; out_ready5 = 1'b1;
    #1;
    checkOutput("w5_rst_valid", out_valid5, 0);
    checkOutput("w5_rst_ready", in_ready5, 1);
    checkOutput("w5_rst_pos", out_pos5, 0);
    checkOutput("w5_rst_idx", out_idx5, 0);
    checkOutput("w5_rst_last", out_last5, 0);
    checkOutput("w5_rst_none", out_none5, 0);
    step();
    checkOutput("w5_no_accept_in_reset", out_valid5, 0);

    // WIDTH=5 all ones, MSB first: positions 4..0, never past WIDTH-1.
    in5 = 5'b11111; msb5 = 1'b1; in_valid5 = 1'b1;
    step();
    in_valid5 = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("w5_full_pos%0d", k), out_pos5, 4 - k);
      checkOutput($sformatf("w5_full_idx%0d", k), out_idx5, k);
      step();
    end
    checkOutput("w5_full_done", out_valid5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
